// File: rtl/sysarray_feeder.sv
// Operand feeder for the 4x3 output-stationary systolic array.
// Holds A (4xK) and B (Kx3). On start it pulses the array clear, then streams
// skewed, zero-padded rows and columns for K+5 steps, and flags when C is final.

// One skew lane: picks element (step - LANE) of its row/column, or 0 outside 0..K-1.
module sysarray_feeder_lane #(
  parameter int data_size = 8,
  parameter int K         = 4,
  parameter int LANE      = 0,
  parameter int CW        = 4
) (
  input  logic [CW-1:0]               step,
  input  logic [K-1:0][data_size-1:0] vec,
  output logic [data_size-1:0]        elem
);
  // mux the element whose diagonal slot matches this step
  always_comb begin
    elem = '0;
    for (int k = 0; k < K; k++)
      if (int'(step) == k + LANE) elem = vec[k];
  end
endmodule

module sysarray_feeder #(
  parameter int data_size = 8,
  parameter int K         = 4,
  parameter int ADDR_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [data_size-1:0] wr_data,
  input  logic                 start,
  output logic [data_size-1:0] a1,
  output logic [data_size-1:0] a2,
  output logic [data_size-1:0] a3,
  output logic [data_size-1:0] a4,
  output logic [data_size-1:0] b1,
  output logic [data_size-1:0] b2,
  output logic [data_size-1:0] b3,
  output logic                 arr_clr,
  output logic                 busy,
  output logic                 done
);
  localparam int CW = $clog2(K + 6);
  localparam int IA = $clog2(4 * K);
  localparam int IB = $clog2(3 * K);
  localparam logic [ADDR_W:0] A_N  = (ADDR_W + 1)'(4 * K);
  localparam logic [ADDR_W:0] B_N  = (ADDR_W + 1)'(3 * K);
  localparam logic [CW-1:0]   LAST = CW'(K + 4);

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DONE} state_t;

  state_t state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] step_nxt;

  logic [4*K-1:0][data_size-1:0]  abuf;
  logic [3*K-1:0][data_size-1:0]  bbuf;
  logic [3:0][K-1:0][data_size-1:0] arow;
  logic [2:0][K-1:0][data_size-1:0] bcol;
  logic [3:0][data_size-1:0] a_nxt, a_q;
  logic [2:0][data_size-1:0] b_nxt, b_q;

  // operand buffers: loaded only while idle, out-of-range addresses dropped, never reset
  always_ff @(posedge clk) begin
    if (state == IDLE && wr_en) begin
      if (!wr_sel && {1'b0, wr_addr} < A_N) abuf[wr_addr[IA-1:0]] <= wr_data;
      if ( wr_sel && {1'b0, wr_addr} < B_N) bbuf[wr_addr[IB-1:0]] <= wr_data;
    end
  end

  // A rows are contiguous; B columns are gathered with stride 3
  for (genvar r = 0; r < 4; r++) begin : g_arow
    assign arow[r] = abuf[r*K +: K];
  end
  for (genvar c = 0; c < 3; c++) begin : g_bcol
    for (genvar k = 0; k < K; k++) begin : g_k
      assign bcol[c][k] = bbuf[k*3 + c];
    end
  end

  // outputs are registered, so look up the step that will be on the bus next cycle
  assign step_nxt = (state == CLEAR) ? '0 : cnt + 1'b1;

  for (genvar r = 0; r < 4; r++) begin : g_alane
    sysarray_feeder_lane #(.data_size(data_size), .K(K), .LANE(r), .CW(CW)) u_lane (
      .step(step_nxt), .vec(arow[r]), .elem(a_nxt[r]));
  end
  for (genvar c = 0; c < 3; c++) begin : g_blane
    sysarray_feeder_lane #(.data_size(data_size), .K(K), .LANE(c), .CW(CW)) u_lane (
      .step(step_nxt), .vec(bcol[c]), .elem(b_nxt[c]));
  end

  // run sequencer: clear -> K+5 stream steps -> done pulse, all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      arr_clr <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state   <= CLEAR;
          arr_clr <= 1'b1;
          busy    <= 1'b1;
        end
        CLEAR: begin
          state   <= STREAM;
          arr_clr <= 1'b0;
          cnt     <= '0;
          a_q     <= a_nxt;
          b_q     <= b_nxt;
        end
        STREAM: if (cnt == LAST) begin
          state <= DONE;
          done  <= 1'b1;
          a_q   <= '0;
          b_q   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
          a_q <= a_nxt;
          b_q <= b_nxt;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign a1 = a_q[0];
  assign a2 = a_q[1];
  assign a3 = a_q[2];
  assign a4 = a_q[3];
  assign b1 = b_q[0];
  assign b2 = b_q[1];
  assign b3 = b_q[2];
endmodule

// File: tb/tb_sysarray_feeder.sv
// Bench for sysarray_feeder: per-cycle stream check against the skew rule, and C
// rebuilt from the observed streams with an ideal output-stationary array.
module tb_sysarray_feeder;
  localparam int D = 8, K = 4, AW = 8, T = K + 5, CMOD = 131072;

  logic clk = 1'b0;
  logic reset, wr_en, wr_sel, start;
  logic [AW-1:0] wr_addr;
  logic [D-1:0]  wr_data;
  logic [D-1:0]  a1, a2, a3, a4, b1, b2, b3;
  logic          arr_clr, busy, done;
  logic [3:0][D-1:0] av;
  logic [2:0][D-1:0] bv;

  sysarray_feeder #(.data_size(D), .K(K), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .a1(a1), .a2(a2), .a3(a3), .a4(a4),
    .b1(b1), .b2(b2), .b3(b3), .arr_clr(arr_clr), .busy(busy), .done(done));

  always #5 clk = ~clk;
  assign av = {a4, a3, a2, a1};
  assign bv = {b3, b2, b1};

  typedef struct packed {
    logic [15:0][7:0]  a;
    logic [11:0][7:0]  b;
    logic [11:0][16:0] c;
  } vec_t;
  vec_t tbl [3];

  int nchk = 0, nerr = 0;
  int sa [16];          // shadow A, row*K+col
  int sb [12];          // shadow B, k*3+col
  int obsa [T][4];
  int obsb [T][3];
  int expc [12];

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int ea(int r, int t);
    int i = t - r;
    return (i >= 0 && i < K) ? sa[r*K + i] : 0;
  endfunction

  function automatic int eb(int c, int t);
    int i = t - c;
    return (i >= 0 && i < K) ? sb[i*3 + c] : 0;
  endfunction

  // t < 0 means all streams must be zero
  task automatic check_outs(input string nm, input int clr, input int bz, input int dn, input int t);
    chk({nm, ".arr_clr"}, int'(arr_clr), clr);
    chk({nm, ".busy"}, int'(busy), bz);
    chk({nm, ".done"}, int'(done), dn);
    for (int r = 0; r < 4; r++) chk($sformatf("%s.a%0d", nm, r+1), int'(av[r]), (t < 0) ? 0 : ea(r, t));
    for (int c = 0; c < 3; c++) chk($sformatf("%s.b%0d", nm, c+1), int'(bv[c]), (t < 0) ? 0 : eb(c, t));
  endtask

  task automatic write_elem(input bit sel, input int addr, input int data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr[AW-1:0]; wr_data = data[D-1:0];
    @(negedge clk);
    wr_en = 1'b0;
    if (!sel && addr < 4*K) sa[addr] = data;
    if ( sel && addr < 3*K) sb[addr] = data;
  endtask

  task automatic model_c(output int c [12]);
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 3; j++) begin
        longint s = 0;
        for (int k = 0; k < K; k++) s += longint'(sa[r*K + k]) * longint'(sb[k*3 + j]);
        c[r*3 + j] = int'(s % CMOD);
      end
  endtask

  // mode 0 plain; 1 = start and a write poked mid-stream; 2 = write in the start cycle
  task automatic do_run(input int mode, input int ec [12], input string nm);
    start = 1'b1;
    if (mode == 2) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'd2; sa[0] = 2;
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    check_outs({nm, ".c1"}, 1, 1, 0, -1);
    for (int j = 2; j <= K + 7; j++) begin
      @(negedge clk);
      if (j <= K + 6) begin
        check_outs($sformatf("%s.c%0d", nm, j), 0, 1, 0, j - 2);
        for (int r = 0; r < 4; r++) obsa[j-2][r] = int'(av[r]);
        for (int c = 0; c < 3; c++) obsb[j-2][c] = int'(bv[c]);
      end else begin
        check_outs($sformatf("%s.c%0d", nm, j), 0, 1, 1, -1);
      end
      if (mode == 1 && j == 4) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'd99;
      end
      if (mode == 1 && j == 5) begin
        start = 1'b0; wr_en = 1'b0;
      end
    end
    @(negedge clk);
    check_outs({nm, ".idle"}, 0, 0, 0, -1);
    // ideal array: PE(r,c) multiplies a_r delayed c with b_c delayed r
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++) begin
        longint s = 0;
        for (int t = 0; t < T + 6; t++) begin
          int ia = t - c, ib = t - r;
          if (ia >= 0 && ia < T && ib >= 0 && ib < T)
            s += longint'(obsa[ia][r]) * longint'(obsb[ib][c]);
        end
        chk($sformatf("%s.C%0d", nm, r*3 + c + 1), int'(s % CMOD), ec[r*3 + c]);
      end
  endtask

  task automatic load_tbl(input int i);
    for (int e = 0; e < 16; e++) write_elem(1'b0, e, int'(tbl[i].a[e]));
    for (int e = 0; e < 12; e++) write_elem(1'b1, e, int'(tbl[i].b[e]));
    for (int e = 0; e < 12; e++) expc[e] = int'(tbl[i].c[e]);
  endtask

  initial begin
    // directed matrices: all ones, all 255 (wraps mod 2^17), identity x B
    for (int e = 0; e < 16; e++) begin
      tbl[0].a[e] = 8'd1;
      tbl[1].a[e] = 8'd255;
      tbl[2].a[e] = (e / 4 == e % 4) ? 8'd1 : 8'd0;
    end
    for (int e = 0; e < 12; e++) begin
      tbl[0].b[e] = 8'd1;   tbl[0].c[e] = 17'd4;
      tbl[1].b[e] = 8'd255; tbl[1].c[e] = 17'd129028;
      tbl[2].b[e] = 8'(e + 1); tbl[2].c[e] = 17'(e + 1);
    end

    reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    repeat (2) @(negedge clk);
    check_outs("reset", 0, 0, 0, -1);
    reset = 1'b0;
    @(negedge clk);
    check_outs("post_reset", 0, 0, 0, -1);

    for (int i = 0; i < 3; i++) begin
      load_tbl(i);
      do_run(0, expc, $sformatf("tbl%0d", i));
    end

    // start and write while streaming are both ignored
    do_run(1, expc, "busy_ignore");

    // reset in stream cycle 4 aborts the run with no done
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_outs("abort", 0, 0, 0, -1);
    reset = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      chk($sformatf("abort.nodone%0d", n), int'(done), 0);
    end
    do_run(0, expc, "after_abort");

    // out-of-range writes leave buffers alone
    write_elem(1'b0, 16, 77);
    write_elem(1'b1, 12, 77);
    do_run(0, expc, "oob");

    // write in the start cycle lands in this run: A[0][0]=2 doubles row 0 of C
    expc[0] = 2; expc[1] = 4; expc[2] = 6;
    do_run(2, expc, "wr_start");

    for (int n = 0; n < 12; n++) begin
      for (int e = 0; e < 16; e++) write_elem(1'b0, e, int'($urandom_range(0, 255)));
      for (int e = 0; e < 12; e++) write_elem(1'b1, e, int'($urandom_range(0, 255)));
      for (int w = 0; w < 4; w++)
        write_elem(1'($urandom_range(0, 1)), int'($urandom_range(0, 20)), int'($urandom_range(0, 255)));
      model_c(expc);
      do_run(0, expc, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
